// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, synchronous write, synchronous reset to INIT_VALUE.
// Define DATA_MEMORY_WRITE_LOG_EN to log committed writes and flag out-of-range write attempts.
module data_memory #(
    parameter int          DEPTH      = 256,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    output logic [31:0] readData,
    output logic        addrError
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          inRange;
    logic [AW-1:0] wordIdx;

    // The full 32-bit address is range-checked, so truncating to AW bits never aliases.
    assign inRange = (address < DEPTH_W);
    assign wordIdx = address[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VALUE;
            end
        end else if (memWrite && inRange) begin
            mem[wordIdx] <= writeData;
        end
    end

    always_comb begin
        readData  = '0;
        addrError = (memRead | memWrite) & ~inRange;
        if (memRead && inRange) begin
            readData = mem[wordIdx];
        end
    end

`ifdef DATA_MEMORY_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && memWrite) begin
            if (inRange) begin
                $display("%0t data_memory write addr=%0d data=%08h", $time, address, writeData);
            end else begin
                $error("%0t data_memory write out of range addr=%0d data=%08h", $time, address, writeData);
            end
        end
    end
`else
    // Logging disabled: no simulation-only statements in this build.
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with a scoreboard queue of expected {addrError, readData}.
module tb_data_memory;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] readData;
    logic        addrError;

    logic [32:0] sb [$];
    logic [31:0] model [DEPTH];
    int          total = 0;
    int          bad   = 0;

    data_memory #(.DEPTH(DEPTH), .INIT_VALUE(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .writeData (writeData),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .readData  (readData),
        .addrError (addrError)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        memRead   = r;
        memWrite  = w;
        address   = a;
        writeData = d;
    endtask

    task automatic expectOut(input logic ae, input logic [31:0] rd);
        sb.push_back({ae, rd});
    endtask

    task automatic checkOut(input string tag);
        logic [32:0] exp;
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, {addrError, readData});
        end else begin
            exp = sb.pop_front();
            assert ({addrError, readData} === exp) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, {addrError, readData}, exp);
            end
        end
    endtask

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d);
        tick();
        if (a < DEPTH) model[a] = d;
    endtask

    initial begin
        logic [31:0] addrs [12];
        logic [31:0] val;

        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;

        // Reset state
        drive(1'b1, 1'b0, 32'd5, 32'd0);
        expectOut(1'b0, 32'h0000_0000); checkOut("rst_read5");
        address = 32'd255;
        expectOut(1'b0, 32'h0000_0000); checkOut("rst_read255");

        // Write 10, then read+write 18, then disabled write
        drive(1'b0, 1'b1, 32'd10, 32'hDEAD_0000);
        expectOut(1'b0, 32'h0); checkOut("wr10_noread");
        tick();
        model[10] = 32'hDEAD_0000;
        drive(1'b1, 1'b1, 32'd18, 32'h0000_BEEF);
        expectOut(1'b0, 32'h0); checkOut("rw18_before");
        tick();
        model[18] = 32'h0000_BEEF;
        expectOut(1'b0, 32'h0000_BEEF); checkOut("rw18_after");
        drive(1'b1, 1'b0, 32'd10, 32'h1234_5678);
        expectOut(1'b0, 32'hDEAD_0000); checkOut("rd10");
        tick();
        address = 32'd18;
        expectOut(1'b0, 32'h0000_BEEF); checkOut("rd18_nowrite");

        // memRead=0 forces zero
        drive(1'b0, 1'b0, 32'd10, 32'h0);
        expectOut(1'b0, 32'h0); checkOut("noread10");
        address = 32'd300;
        expectOut(1'b0, 32'h0); checkOut("noread300_noerr");

        // Out-of-range write at DEPTH
        drive(1'b0, 1'b1, DEPTH, 32'hFFFF_FFFF);
        expectOut(1'b1, 32'h0); checkOut("oor_write_err");
        tick();
        drive(1'b0, 1'b1, 32'd266, 32'hFFFF_FFFF);
        expectOut(1'b1, 32'h0); checkOut("oor_write266_err");
        tick();
        drive(1'b1, 1'b0, DEPTH, 32'h0);
        expectOut(1'b1, 32'h0); checkOut("oor_read");
        address = 32'hFFFF_FFFF;
        expectOut(1'b1, 32'h0); checkOut("oor_read_max");
        address = 32'd0;
        expectOut(1'b0, 32'h0); checkOut("oor_w0_unchanged");
        address = 32'd10;
        expectOut(1'b0, 32'hDEAD_0000); checkOut("oor_w10_unchanged");
        tick();

        // Read-during-write at address 7
        modelWrite(32'd7, 32'h1111_1111);
        drive(1'b1, 1'b1, 32'd7, 32'h2222_2222);
        expectOut(1'b0, 32'h1111_1111); checkOut("rdw7_before");
        tick();
        model[7] = 32'h2222_2222;
        expectOut(1'b0, 32'h2222_2222); checkOut("rdw7_after");

        // Independent writes across the array including both ends
        addrs[0] = 32'd0;
        addrs[1] = 32'd255;
        for (int i = 2; i < 12; i++) addrs[i] = (i * 37 + 1) % DEPTH;
        for (int i = 0; i < 12; i++) begin
            val = $urandom;
            modelWrite(addrs[i], val);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, addrs[i], 32'h0);
            expectOut(1'b0, model[addrs[i]]);
            checkOut($sformatf("indep_a%0d", addrs[i]));
            tick();
        end
        foreach (addrs[i]) begin
            drive(1'b1, 1'b0, addrs[i] + 32'd1 < DEPTH ? addrs[i] + 32'd1 : 32'd1, 32'h0);
            expectOut(1'b0, model[address]);
            checkOut($sformatf("neigh_a%0d", address));
            tick();
        end

        // Reset wins over simultaneous write and clears prior data
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'd3, 32'hA5A5_A5A5);
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        drive(1'b1, 1'b0, 32'd3, 32'h0);
        expectOut(1'b0, 32'h0); checkOut("rst_prio3");
        address = 32'd10;
        expectOut(1'b0, 32'h0); checkOut("rst_clear10");
        address = 32'd7;
        expectOut(1'b0, 32'h0); checkOut("rst_clear7");
        address = 32'd255;
        expectOut(1'b0, 32'h0); checkOut("rst_clear255");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words stored.
REQ-002 Parameter INIT_VALUE, default 32'h0000_0000, value loaded into every word on reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address  input  32  word index, not byte address; word N selected by address value N.
REQ-006 writeData  input  32  data written at the selected word.
REQ-007 memRead  input  1  read enable.
REQ-008 memWrite  input  1  write enable.
REQ-009 readData  output  32  read data.
REQ-010 addrError  output  1  high when an enabled access targets address >= DEPTH.

Function
REQ-011 Storage SHALL be DEPTH words of 32 bits, indexed by address[31:0] compared as unsigned.
REQ-012 Write SHALL occur on the rising clk edge when memWrite=1, reset=0 and address < DEPTH: mem[address] <= writeData.
REQ-013 Read SHALL be combinational, with no clock latency: readData = mem[address] when memRead=1 and address < DEPTH; otherwise readData = 0.
REQ-014 readData SHALL follow address and memRead changes between clock edges within the same delta cycle.
REQ-015 memRead=1 and memWrite=1 together SHALL perform both; before the edge readData shows old contents, after the edge it shows writeData.
REQ-016 addrError SHALL be combinational: (memRead|memWrite) & (address >= DEPTH); an out-of-range write SHALL leave all words unchanged.
REQ-017 memWrite=0 SHALL never modify any word regardless of writeData or memRead.
REQ-018 Writes to distinct addresses SHALL be independent; no aliasing below DEPTH.

Reset
REQ-019 While reset=1 at a rising edge, every word SHALL be set to INIT_VALUE; reset SHALL take priority over a simultaneous write.
REQ-020 readData and addrError have no registered state; after reset, a read of any valid address SHALL return INIT_VALUE.
REQ-021 Reset asserted mid-sequence SHALL discard all previously written data at that edge.

Configuration
REQ-022 Macro DATA_MEMORY_WRITE_LOG_EN: when defined, each committed write SHALL print simulation time, address and data via a simulation display statement. Out-of-range write attempts SHALL be printed as errors.
REQ-023 Without DATA_MEMORY_WRITE_LOG_EN, no display statements SHALL exist, and functional behaviour SHALL be identical.

Verification
REQ-024 reset 1 cycle, then memRead=1, address=5 -> readData=0x00000000, addrError=0.
REQ-025 memWrite=1, memRead=0, address=10, writeData=0xDEAD0000 over an edge; then memWrite=1, memRead=1, address=18, writeData=0x0000BEEF over an edge; then memWrite=0, writeData=0x12345678 -> memRead=1 address=10 gives 0xDEAD0000 immediately; address=18 gives 0x0000BEEF (the 0x12345678 value was never written).
REQ-026 memRead=0, any address -> readData=0.
REQ-027 memWrite=1, address=DEPTH, writeData=0xFFFFFFFF -> addrError=1; all words unchanged; read of address DEPTH returns 0 with addrError=1.
REQ-028 memWrite=1 and reset=1 on the same edge, address=3, writeData=0xA5A5A5A5 -> mem[3] reads INIT_VALUE afterwards.
REQ-029 memRead=1, memWrite=1, address=7, old value 0x11111111, writeData=0x22222222 -> readData=0x11111111 before the edge, 0x22222222 after it.
